// File: rtl/q8_8_div_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential Q8.8 divider.
interface q8_8_div_seq_if #(
   parameter int BUS_WIDTH = 16
);
   logic                 start;
   logic [BUS_WIDTH-1:0] dividend;
   logic [BUS_WIDTH-1:0] divisor;
   logic                 busy;
   logic                 done;
   logic [BUS_WIDTH-1:0] quotient;
   logic                 overflow;
   logic                 div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, overflow, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, overflow, div_by_zero
   );
endinterface

// File: rtl/q8_8_div_seq.sv
// Sequential unsigned Q8.8 restoring divider, one quotient bit per cycle, with saturation.
// Optional round-half-up of the quotient is enabled by defining Q8_8_DIV_ROUND_EN.
module q8_8_div_seq #(
   parameter int BUS_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   q8_8_div_seq_if.slave    bus
);
   localparam int FRAC = BUS_WIDTH / 2;
`ifdef Q8_8_DIV_ROUND_EN
   localparam int ITERS = BUS_WIDTH + 1;
`else
   localparam int ITERS = BUS_WIDTH;
`endif
   localparam int CW = $clog2(ITERS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   // After each iteration the remainder is below the divisor, so BUS_WIDTH bits
   // hold it; the 17th bit only exists transiently in the shifted value.
   logic [BUS_WIDTH-1:0] rem_q, rem_d;
   logic [BUS_WIDTH-1:0] sh_q, sh_d;
   logic [BUS_WIDTH-1:0] dvs_q, dvs_d;
   logic [ITERS-2:0]     qacc_q, qacc_d;
   logic [BUS_WIDTH-1:0] quo_q, quo_d;
   logic                 ovf_q, ovf_d;
   logic                 dbz_q, dbz_d;

   logic [BUS_WIDTH:0]   rem_sh, dvs_ext;
   logic                 rem_ge, hi_ge;
   logic [ITERS-1:0]     q_nxt;
   logic [BUS_WIDTH-1:0] q_final;
   logic                 fin_ovf;

   assign dvs_ext = {1'b0, dvs_q};
   assign rem_sh  = {rem_q, sh_q[BUS_WIDTH-1]};
   assign rem_ge  = (rem_sh >= dvs_ext);
   assign q_nxt   = {qacc_q, rem_ge};
   assign hi_ge   = ({{FRAC{1'b0}}, bus.dividend[BUS_WIDTH-1:FRAC]} >= bus.divisor);

`ifdef Q8_8_DIV_ROUND_EN
   logic [BUS_WIDTH:0] rnd_sum;
   // Last iteration is the guard bit; add it to the truncated quotient.
   assign rnd_sum = {1'b0, q_nxt[ITERS-1:1]} + {{BUS_WIDTH{1'b0}}, q_nxt[0]};
   assign q_final = rnd_sum[BUS_WIDTH] ? '1 : rnd_sum[BUS_WIDTH-1:0];
   assign fin_ovf = rnd_sum[BUS_WIDTH];
`else
   assign q_final = q_nxt;
   assign fin_ovf = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         qacc_q  <= '0;
         quo_q   <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         dvs_q   <= dvs_d;
         qacc_q  <= qacc_d;
         quo_q   <= quo_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      dvs_d   = dvs_q;
      qacc_d  = qacc_q;
      quo_d   = quo_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvs_d  = bus.divisor;
               rem_d  = {{FRAC{1'b0}}, bus.dividend[BUS_WIDTH-1:FRAC]};
               sh_d   = {bus.dividend[FRAC-1:0], {FRAC{1'b0}}};
               cnt_d  = '0;
               qacc_d = '0;
               if (bus.divisor == '0) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  ovf_d   = 1'b0;
                  dbz_d   = 1'b1;
               end else if (hi_ge) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  ovf_d   = 1'b1;
                  dbz_d   = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d  = rem_ge ? BUS_WIDTH'(rem_sh - dvs_ext) : rem_sh[BUS_WIDTH-1:0];
            sh_d   = {sh_q[BUS_WIDTH-2:0], 1'b0};
            qacc_d = q_nxt[ITERS-2:0];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(ITERS - 1)) begin
               state_d = S_DONE;
               quo_d   = q_final;
               ovf_d   = fin_ovf;
               dbz_d   = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.quotient    = quo_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dbz_q;
endmodule
